vga_scanout: RTL and testbench
==============================

# vga_scanout

Display-side reader for the 640x480 12-bit VRAM written by the graphics processor. It generates 640x480@60 VGA timing, issues VRAM read addresses in raster order, and registers the returned 12-bit pixels onto the RGB pins with matching sync. It also exports a vertical-blank status and a frame-start pulse, so software can schedule fill/draw commands outside the visible region.

## Interface
- `CLK_DIV`, 4: `clk` cycles per pixel; legal range ≥ 2.
- `H_VIS/H_FP/H_SYNC/H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_VIS/V_FP/V_SYNC/V_BP`, 480/10/2/33: vertical timing, in lines.

Ports:
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: reset. Synchronous and active-high.
- `vram_addr`, out, 19: VRAM read address, row-major (`y*640 + x`).
- `vram_data`, in, 12: VRAM read data. Synchronous read, valid one `clk` after `vram_addr`.
- `r`, `g`, `b`, out, 4 each: pixel colour. Sourced from `vram_data[11:8]`, `[7:4]` and `[3:0]`.
- `hs`, `vs`, out, 1 each: syncs, active-low.
- `vblank`, out, 1: high while the output line is ≥ `V_VIS`.
- `frame_start`, out, 1: one-`clk` pulse when output pixel (0,0) is presented.

## Operation
**Pixel tick**
- A divider counts 0..`CLK_DIV-1`.
- `tick` is asserted for the single `clk` in which the divider equals `CLK_DIV-1`.
- Nothing outside the divider changes on non-tick cycles.

**Scan counters**
- `h_cnt` runs 0..799 and wraps to 0.
- `v_cnt` advances only on an `h_cnt` wrap, runs 0..524 and wraps to 0.
- Visible region: `h_cnt < 640` and `v_cnt < 480`.

**Address generation**
- `vram_addr` is a register and always holds the address of the current (`h_cnt`, `v_cnt`).
- It is updated in the same `clk` as the counters.
- Arithmetic is incremental, with no multiplier:
  - +1 inside a visible line.
  - A line-base register steps +640 per line.
  - Both are cleared at the frame wrap.
- During blanking, `vram_addr` holds the next visible address:
  - H-blank: start of the next line.
  - V-blank: 0.
- 19-bit width; the maximum value is 307199, so it never overflows.

**Output stage**
- Registered, updated only on `tick`.
- On `tick` it captures the pixel whose address was presented during the preceding slot:
  - RGB = `vram_data` if that pixel was visible, otherwise 0.
  - `hs` = 0 when `656 ≤ h` ≤ 751.
  - `vs` = 0 when `490 ≤ v` ≤ 491.
- `vblank` and `frame_start` are derived from the same delayed coordinates.

**Reset values**
- Divider, `h_cnt`, `v_cnt`, `vram_addr`: 0.
- `r`, `g`, `b`: 0.
- `hs`, `vs`: 1.
- `vblank`, `frame_start`: 0.

**Reset mid-frame**
- Takes effect at the next `clk` edge.
- Aborts the frame; scan restarts at (0,0) with no partial-line artefacts beyond the reset cycle.

**Simultaneous `h` and `v` wrap** (at 799/524)
- Both counters and `vram_addr` return to 0 in the same `clk`.

## Timing
- Read latency: address → data is 1 `clk`. `CLK_DIV ≥ 2` guarantees the data is stable before the capturing `tick`.
- Pixel pipeline: the pixel at counter position p appears on RGB one pixel slot (`CLK_DIV` clk) later.
- Syncs are delayed identically to RGB, so the pins stay aligned.
- Frame period: 800 × 525 × `CLK_DIV` clk, which is 1,680,000 at `CLK_DIV`=4.
- `frame_start` is exactly 1 `clk` wide, once per frame.
- `vblank` rises at output line 480 and falls at output line 0.

## Structure
- Shared package `vga_pkg` holds:
  - The timing constants.
  - Derived totals (`H_TOTAL`=800, `V_TOTAL`=525).
  - Sync-window bounds.
  - `VRAM_W`=640, `VRAM_H`=480, `VRAM_AW`=19.
  - The 12-bit colour field positions.
- The graphics processor reuses `VRAM_W` from the same package.
- One sub-module, `vga_timing`, contains:
  - The divider.
  - The `h`/`v` counters.
  - Combinational `tick`, visible, hsync-window and vsync-window flags.
- `vga_scanout` adds the address generator and the output pipeline.

## Test plan
1. **Reset values and first output.** Hold `rst` 3 clk, then release. Expect all outputs at their reset values; `vram_addr`=0; first `tick` on the 4th clk after release; first output pixel equals `vram_data` at addr 0.
2. **Address and pixel mapping.** Model VRAM as `data = addr[11:0]`. Expect:
   - Output pixel (5,0) = 12'h005.
   - Pixel (0,1) read from addr 640.
   - Pixel (639,479) read from addr 307199, colour 12'hFFF.
3. **Horizontal sync and blanking.** Count output pixels per line. Expect:
   - `hs` low for exactly 96 pixels (384 clk), starting at output pixel 656.
   - RGB = 0 for pixels 640..799 even when VRAM returns 12'hABC.
4. **Vertical timing.** Expect:
   - `vs` low for exactly 2 lines, starting at line 490.
   - `vblank` high for lines 480..524.
   - `frame_start` pulses spaced exactly 1,680,000 clk apart.
5. **Reset mid-frame.** Assert `rst` at line 200, pixel 300, then release. Expect `vram_addr` back to 0 next clk and the following full frame bit-identical to the frame from scenario 1.
6. **Minimum divider.** `CLK_DIV`=2 with VRAM returning data exactly 1 clk after the address. Expect no pixel shift; scenario 2 checks still pass; frame period 840,000 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: constants shared by the display scanout and the graphics processor.
// Contents:
//   - 640x480@60 timing constants and the derived line/frame totals
//   - sync-window bounds
//   - VRAM geometry: VRAM_W, VRAM_H and address width VRAM_AW
//   - 12-bit colour field positions and a helper that splits a pixel into R/G/B
package vga_pkg;

  localparam int CLK_DIV_DEFAULT = 4;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  localparam int H_SYNC_FIRST = H_VIS + H_FP;                // 656
  localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;   // 751
  localparam int V_SYNC_FIRST = V_VIS + V_FP;                // 490
  localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;   // 491

  localparam int VRAM_W  = 640;
  localparam int VRAM_H  = 480;
  localparam int VRAM_AW = 19;

  localparam int COLOR_W = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 8;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 0;

  typedef logic [COLOR_W-1:0] pixel_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  function automatic rgb_t unpack_pixel(input pixel_t p);
    rgb_t c;
    c.r = p[R_LSB +: CH_W];
    c.g = p[G_LSB +: CH_W];
    c.b = p[B_LSB +: CH_W];
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-clock divider and raster counters.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   tick              - one clk per pixel slot (divider at CLK_DIV-1)
//   h_cnt, v_cnt      - current raster position, advanced on tick
//   h_last, v_last    - counter is at its final value (wraps on next tick)
//   visible           - current position lies in the active picture
//   hs_win, vs_win    - current position lies inside the sync pulse window
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = vga_pkg::CLK_DIV_DEFAULT,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int H_CW   = $clog2(H_TOT),
  localparam int V_CW   = $clog2(V_TOT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick,
  output logic [H_CW-1:0] h_cnt,
  output logic [V_CW-1:0] v_cnt,
  output logic            h_last,
  output logic            v_last,
  output logic            visible,
  output logic            hs_win,
  output logic            vs_win
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HS_LO = H_VIS + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_VIS + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign h_last = (h_cnt == H_CW'(H_TOT - 1));
  assign v_last = (v_cnt == V_CW'(V_TOT - 1));

  // v_cnt only moves on the tick that wraps h_cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + V_CW'(1);
      end else begin
        h_cnt <= h_cnt + H_CW'(1);
      end
    end
  end

  assign visible = (h_cnt < H_CW'(H_VIS)) && (v_cnt < V_CW'(V_VIS));
  assign hs_win  = (h_cnt >= H_CW'(HS_LO)) && (h_cnt <= H_CW'(HS_HI));
  assign vs_win  = (v_cnt >= V_CW'(VS_LO)) && (v_cnt <= V_CW'(VS_HI));

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster reader for the 12-bit VRAM with VGA sync generation.
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   vram_addr           - registered VRAM read address, row-major y*H_VIS+x
//   vram_data           - VRAM read data, valid one clk after vram_addr
//   r, g, b             - registered pixel colour, 4 bits each
//   hs, vs              - active-low syncs, aligned with r/g/b
//   vblank              - output line is in vertical blanking
//   frame_start         - one-clk pulse when output pixel (0,0) is presented
// The line stride is H_VIS, which equals VRAM_W in the standard 640x480 mode.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV = vga_pkg::CLK_DIV_DEFAULT,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [COLOR_W-1:0] vram_data,
  output logic [CH_W-1:0]    r,
  output logic [CH_W-1:0]    g,
  output logic [CH_W-1:0]    b,
  output logic               hs,
  output logic               vs,
  output logic               vblank,
  output logic               frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_CW  = $clog2(H_TOT);
  localparam int V_CW  = $clog2(V_TOT);

  logic            tick;
  logic [H_CW-1:0] h_cnt;
  logic [V_CW-1:0] v_cnt;
  logic            h_last;
  logic            v_last;
  logic            visible;
  logic            hs_win;
  logic            vs_win;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .h_last  (h_last),
    .v_last  (v_last),
    .visible (visible),
    .hs_win  (hs_win),
    .vs_win  (vs_win)
  );

  // ---- stage p0: address generation, moves with the counters ----
  logic [VRAM_AW-1:0] line_base_p0;
  logic               line_end_p0;
  logic               last_line_p0;

  assign line_end_p0  = visible && (h_cnt == H_CW'(H_VIS - 1));
  assign last_line_p0 = (v_cnt == V_CW'(V_VIS - 1));

  // Leaving the last visible pixel of a line jumps straight to the start of
  // the next visible line (or 0 after the bottom line), so during blanking
  // the address already points at the next pixel that will be shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr    <= '0;
      line_base_p0 <= '0;
    end else if (tick) begin
      if (h_last && v_last) begin
        vram_addr    <= '0;
        line_base_p0 <= '0;
      end else if (line_end_p0) begin
        if (last_line_p0) begin
          vram_addr    <= '0;
          line_base_p0 <= '0;
        end else begin
          vram_addr    <= line_base_p0 + VRAM_AW'(H_VIS);
          line_base_p0 <= line_base_p0 + VRAM_AW'(H_VIS);
        end
      end else if (visible) begin
        vram_addr <= vram_addr + VRAM_AW'(1);
      end
    end
  end

  // ---- stage p1: output registers, capture the slot just finished ----
  // The counters still describe the previous slot on the tick, so their flags
  // line up with the data returned for the address issued in that slot.
  rgb_t rgb_p1;
  logic hs_p1;
  logic vs_p1;
  logic vblank_p1;
  logic fs_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1    <= '0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
      vblank_p1 <= 1'b0;
      fs_p1     <= 1'b0;
    end else begin
      fs_p1 <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        rgb_p1    <= visible ? unpack_pixel(vram_data) : '0;
        hs_p1     <= ~hs_win;
        vs_p1     <= ~vs_win;
        vblank_p1 <= (v_cnt >= V_CW'(V_VIS));
      end
    end
  end

  assign r           = rgb_p1.r;
  assign g           = rgb_p1.g;
  assign b           = rgb_p1.b;
  assign hs          = hs_p1;
  assign vs          = vs_p1;
  assign vblank      = vblank_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout using a reduced raster (16x8 visible, 24x15 total)
// so full frames fit in a short run; a second instance uses CLK_DIV=2.
module tb_vga_scanout;

  localparam int D   = 4;
  localparam int HV  = 16, HFP = 2, HSY = 4, HBP = 2;
  localparam int VV  = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam int HT  = HV + HFP + HSY + HBP;   // 24
  localparam int VT  = VV + VFP + VSY + VBP;   // 15
  localparam int FRAME = HT * VT * D;          // 1440 clk

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abc_mode = 1'b0;

  logic [18:0] vram_addr, vram_addr2;
  logic [11:0] vram_data, vram_data2;
  logic [3:0]  r, g, b, r2, g2, b2;
  logic        hs, vs, vblank, frame_start;
  logic        hs2, vs2, vblank2, frame_start2;

  always #5 clk = ~clk;

  // Synchronous-read VRAM models: data follows the address by one clk
  always @(posedge clk) begin
    vram_data  <= abc_mode ? 12'hABC : vram_addr[11:0];
    vram_data2 <= vram_addr2[11:0];
  end

  vga_scanout #(
    .CLK_DIV(D), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) u_dut (
    .clk(clk), .rst(rst), .vram_addr(vram_addr), .vram_data(vram_data),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .vblank(vblank),
    .frame_start(frame_start)
  );

  vga_scanout #(
    .CLK_DIV(2), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) u_div2 (
    .clk(clk), .rst(rst), .vram_addr(vram_addr2), .vram_data(vram_data2),
    .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .vblank(vblank2),
    .frame_start(frame_start2)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;            // posedges since rst was released
  bit rec = 1'b0;
  bit cmp = 1'b0;
  int mism = 0;
  int first_mism = -1;
  logic [34:0] ref_frame [FRAME];

  typedef struct {
    string       name;
    int          n;
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  function automatic logic [34:0] outv();
    return {r, g, b, hs, vs, vblank, frame_start, vram_addr};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (n=%0d): got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    if (n >= 1 && n <= FRAME) begin
      if (rec) ref_frame[n-1] = outv();
      if (cmp && outv() !== ref_frame[n-1]) begin
        mism++;
        if (first_mism < 0) first_mism = n;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  initial begin
    int fs_at, cnt_hs, cnt_vs, cnt_vb, guard;

    //          name          n     addr  rgb     hs vs vb fs
    vec[0]  = '{"reset",        0,    0, 12'h000, 1, 1, 0, 0};
    vec[1]  = '{"pre_tick",     3,    0, 12'h000, 1, 1, 0, 0};
    vec[2]  = '{"first_px",     4,    1, 12'h000, 1, 1, 0, 1};
    vec[3]  = '{"fs_width",     5,    1, 12'h000, 1, 1, 0, 0};
    vec[4]  = '{"px_5_0",      24,    6, 12'h005, 1, 1, 0, 0};
    vec[5]  = '{"px_14_0",     60,   15, 12'h00E, 1, 1, 0, 0};
    vec[6]  = '{"px_15_0",     64,   16, 12'h00F, 1, 1, 0, 0};
    vec[7]  = '{"hblank_17",   72,   16, 12'h000, 1, 1, 0, 0};
    vec[8]  = '{"hs_first",    76,   16, 12'h000, 0, 1, 0, 0};
    vec[9]  = '{"hs_last",     88,   16, 12'h000, 0, 1, 0, 0};
    vec[10] = '{"hs_after",    92,   16, 12'h000, 1, 1, 0, 0};
    vec[11] = '{"line1_addr",  96,   16, 12'h000, 1, 1, 0, 0};
    vec[12] = '{"px_0_1",     100,   17, 12'h010, 1, 1, 0, 0};
    vec[13] = '{"px_14_7",    732,  127, 12'h07E, 1, 1, 0, 0};
    vec[14] = '{"px_15_7",    736,    0, 12'h07F, 1, 1, 0, 0};
    vec[15] = '{"vb_before",  768,    0, 12'h000, 1, 1, 0, 0};
    vec[16] = '{"vb_rise",    772,    0, 12'h000, 1, 1, 1, 0};
    vec[17] = '{"vs_before",  960,    0, 12'h000, 1, 1, 1, 0};
    vec[18] = '{"vs_first",   964,    0, 12'h000, 1, 0, 1, 0};
    vec[19] = '{"vs_last",   1152,    0, 12'h000, 1, 0, 1, 0};
    vec[20] = '{"frame_wrap",1440,    0, 12'h000, 1, 1, 1, 0};
    vec[21] = '{"frame2_px0",1444,    1, 12'h000, 1, 1, 0, 1};

    // Reset state, mapping, sync and blanking vectors; also records frame 1
    do_reset();
    rec = 1'b1;
    for (int i = 0; i < NV; i++) begin
      while (n < vec[i].n) step();
      check({vec[i].name, "_addr"}, 35'(vram_addr), 35'(vec[i].addr));
      check({vec[i].name, "_rgb"},  35'({r, g, b}), 35'(vec[i].rgb));
      check({vec[i].name, "_sync"}, 35'({hs, vs}),  35'({vec[i].hs, vec[i].vs}));
      check({vec[i].name, "_vb"},   35'(vblank),    35'(vec[i].vb));
      check({vec[i].name, "_fs"},   35'(frame_start), 35'(vec[i].fs));
    end
    rec = 1'b0;

    // Frame period and per-frame sync/blank durations
    fs_at = n;
    cnt_hs = 0; cnt_vs = 0; cnt_vb = 0; guard = 0;
    do begin
      step();
      guard++;
      if (!hs) cnt_hs++;
      if (!vs) cnt_vs++;
      if (vblank) cnt_vb++;
    end while (!frame_start && guard < 2 * FRAME);
    check("frame_period", 35'(n - fs_at), 35'(FRAME));
    check("hs_low_clk",   35'(cnt_hs), 35'(VT * HSY * D));
    check("vs_low_clk",   35'(cnt_vs), 35'(VSY * HT * D));
    check("vblank_clk",   35'(cnt_vb), 35'((VT - VV) * HT * D));

    // Reset mid-frame at line 5, pixel 10, with the divider part-way through
    fs_at = n;
    while (n < fs_at + (5 * HT + 10) * D + 2) step();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_addr", 35'(vram_addr), 35'(0));
    check("midrst_out",  35'({r, g, b, hs, vs, vblank, frame_start}), 35'({12'h000, 4'b1100}));
    rst = 1'b0;
    n = 0;
    cmp = 1'b1;
    while (n < FRAME) step();
    cmp = 1'b0;
    check("midrst_frame_diffs", 35'(mism), 35'(0));
    if (first_mism >= 0) $display("first differing clk after release: %0d", first_mism);

    // Blanked pixels stay black even when VRAM returns non-zero data
    abc_mode = 1'b1;
    do_reset();
    while (n < HT * D) begin
      step();
      if (n % D == 0)
        check("abc_line", 35'({r, g, b}), ((n / D - 1) < HV) ? 35'(12'hABC) : 35'(0));
    end
    abc_mode = 1'b0;

    // Minimum divider instance
    do_reset();
    while (n < (VT * HT + 1) * 2) begin
      step();
      case (n)
        2:   check("d2_fs_first",  35'(frame_start2), 35'(1));
        3:   check("d2_fs_width",  35'(frame_start2), 35'(0));
        12:  check("d2_px_5_0",    35'({r2, g2, b2}), 35'(12'h005));
        50:  check("d2_px_0_1",    35'({r2, g2, b2}), 35'(12'h010));
        368: check("d2_px_15_7",   35'({r2, g2, b2}), 35'(12'h07F));
        720: check("d2_fs_early",  35'(frame_start2), 35'(0));
        default: ;
      endcase
    end
    check("d2_fs_period", 35'(frame_start2), 35'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
